// File: rtl/tiny_proc_pkg.sv
// Shared definitions for the tiny processor: run-controller state encodings and default widths.
package tiny_proc_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int NIB_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4,
    ST_STEP  = 3'd5
  } run_state_t;

endpackage

// File: rtl/core_run_ctrl_pin_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, exposing the synchronized level
// and a single-cycle rising-edge pulse.
module pin_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/program sequencer: serial nibble load of imem, then flush/run/halt/single-step control.
// Optional breakpoint stall path enabled by defining TINY_PROC_BREAKPOINT_EN.
module core_run_ctrl
  import tiny_proc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode_i,
  input  logic              prog_stb_i,
  input  logic [NIB_W-1:0]  prog_nib_i,
  input  logic              run_i,
  input  logic              halt_i,
  input  logic              step_i,
`ifdef TINY_PROC_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  input  logic              bp_valid_i,
`endif
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_waddr_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  output logic              core_stall_o,
  output logic              core_flush_o,
  output logic [2:0]        state_o
);

  logic mode_lvl, mode_rise;
  logic stb_lvl,  stb_rise;
  logic run_lvl,  run_rise;
  logic halt_lvl, halt_rise;
  logic step_lvl, step_rise;

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clk(clk), .rst(rst), .pin(prog_mode_i), .level(mode_lvl), .rise(mode_rise));
  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stb (
    .clk(clk), .rst(rst), .pin(prog_stb_i), .level(stb_lvl), .rise(stb_rise));
  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_run (
    .clk(clk), .rst(rst), .pin(run_i), .level(run_lvl), .rise(run_rise));
  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_halt (
    .clk(clk), .rst(rst), .pin(halt_i), .level(halt_lvl), .rise(halt_rise));
  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_step (
    .clk(clk), .rst(rst), .pin(step_i), .level(step_lvl), .rise(step_rise));

  // Nibble data rides its own chain of equal depth so it lines up with the strobe edge.
  logic [NIB_W-1:0] nib_sync [SYNC_STAGES];
  logic [NIB_W-1:0] nib_lvl;

  always_ff @(posedge clk) begin
    nib_sync[0] <= prog_nib_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      nib_sync[i] <= nib_sync[i-1];
    end
  end

  assign nib_lvl = nib_sync[SYNC_STAGES-1];

  run_state_t state;
  logic       stall_q;
  logic       nib_hi;

`ifdef TINY_PROC_BREAKPOINT_EN
  logic bp_skip;
  logic bp_hit;

  assign bp_hit       = (state == ST_RUN) && bp_valid_i && (pc_i == bp_addr_i) && !bp_skip;
  assign core_stall_o = stall_q | bp_hit;
`else
  logic bp_hit;

  assign bp_hit       = 1'b0;
  assign core_stall_o = stall_q;
`endif

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      imem_we_o    <= 1'b0;
      imem_waddr_o <= '0;
      imem_wdata_o <= '0;
      stall_q      <= 1'b1;
      core_flush_o <= 1'b0;
      nib_hi       <= 1'b0;
`ifdef TINY_PROC_BREAKPOINT_EN
      bp_skip      <= 1'b0;
`endif
    end else begin
      imem_we_o    <= 1'b0;
      core_flush_o <= 1'b0;
`ifdef TINY_PROC_BREAKPOINT_EN
      bp_skip      <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          stall_q <= 1'b1;
          if (!halt_rise && !step_rise) begin
            if (run_rise) begin
              state        <= ST_FLUSH;
              core_flush_o <= 1'b1;
            end else if (mode_lvl) begin
              state        <= ST_LOAD;
              imem_waddr_o <= '0;
              nib_hi       <= 1'b0;
            end
          end
        end

        ST_LOAD: begin
          stall_q <= 1'b1;
          // The write issued last cycle retires here; the address wraps at the top of imem.
          if (imem_we_o) begin
            imem_waddr_o <= imem_waddr_o + ADDR_W'(1);
          end
          if (!mode_lvl) begin
            state  <= ST_IDLE;
            nib_hi <= 1'b0;
          end else if (stb_rise) begin
            if (!nib_hi) begin
              imem_wdata_o[NIB_W-1:0] <= nib_lvl;
              nib_hi                  <= 1'b1;
            end else begin
              imem_wdata_o[NIB_W +: NIB_W] <= nib_lvl;
              imem_we_o                    <= 1'b1;
              nib_hi                       <= 1'b0;
            end
          end
        end

        ST_FLUSH: begin
          state   <= ST_RUN;
          stall_q <= 1'b0;
        end

        ST_RUN: begin
          if (halt_rise || bp_hit) begin
            state   <= ST_HALT;
            stall_q <= 1'b1;
          end else begin
            stall_q <= 1'b0;
          end
        end

        ST_HALT: begin
          stall_q <= 1'b1;
          if (!halt_rise) begin
            if (step_rise) begin
              state   <= ST_STEP;
              stall_q <= 1'b0;
`ifdef TINY_PROC_BREAKPOINT_EN
              bp_skip <= 1'b1;
`endif
            end else if (run_rise) begin
              state   <= ST_RUN;
              stall_q <= 1'b0;
`ifdef TINY_PROC_BREAKPOINT_EN
              bp_skip <= 1'b1;
`endif
            end else if (mode_lvl) begin
              state        <= ST_LOAD;
              imem_waddr_o <= '0;
              nib_hi       <= 1'b0;
            end
          end
        end

        ST_STEP: begin
          state   <= ST_HALT;
          stall_q <= 1'b1;
        end

        default: begin
          state   <= ST_IDLE;
          stall_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: imem write scoreboard plus control-sequence checks.
module tb_core_run_ctrl;
  import tiny_proc_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_mode_i, prog_stb_i, run_i, halt_i, step_i;
  logic [3:0]        prog_nib_i;
  logic              imem_we_o, core_stall_o, core_flush_o;
  logic [ADDR_W-1:0] imem_waddr_o;
  logic [DATA_W-1:0] imem_wdata_o;
  logic [2:0]        state_o;
`ifdef TINY_PROC_BREAKPOINT_EN
  logic [ADDR_W-1:0] pc_i, bp_addr_i;
  logic              bp_valid_i;
`endif

  core_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .prog_mode_i(prog_mode_i), .prog_stb_i(prog_stb_i), .prog_nib_i(prog_nib_i),
    .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
`ifdef TINY_PROC_BREAKPOINT_EN
    .pc_i(pc_i), .bp_addr_i(bp_addr_i), .bp_valid_i(bp_valid_i),
`endif
    .imem_we_o(imem_we_o), .imem_waddr_o(imem_waddr_o), .imem_wdata_o(imem_wdata_o),
    .core_stall_o(core_stall_o), .core_flush_o(core_flush_o), .state_o(state_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] exp_addr;
  } vec_t;

  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   wr_count = 0;
  logic we_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write scoreboard: every imem write pulse must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (!rst && imem_we_o) begin
      wr_t e;
      wr_count++;
      check("we_single_cycle", {31'd0, we_prev}, 32'd0);
      check("we_in_load", {29'd0, state_o}, 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", imem_waddr_o, imem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {28'd0, imem_waddr_o}, {28'd0, e.addr});
        check("wr_data", {24'd0, imem_wdata_o}, {24'd0, e.data});
      end
    end
    we_prev = imem_we_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] nib);
    prog_nib_i = nib;
    prog_stb_i = 1'b1;
    tick(3);
    prog_stb_i = 1'b0;
    tick(3);
  endtask

  task automatic load_byte(input logic [7:0] b, input logic [3:0] addr);
    wr_t e;
    e.addr = addr;
    e.data = b;
    exp_q.push_back(e);
    strobe(b[3:0]);
    strobe(b[7:4]);
  endtask

  // Samples the next n cycles; times are 1-based cycle indices after the call, -1 if never seen.
  task automatic watch(input int n, output int n_stall0, output int n_flush,
                       output int t_flush, output int t_run, output int t_stall1);
    n_stall0 = 0; n_flush = 0; t_flush = -1; t_run = -1; t_stall1 = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (core_flush_o) begin
        n_flush++;
        if (t_flush < 0) t_flush = k;
      end
      if (!core_stall_o) begin
        n_stall0++;
        if (t_run < 0) t_run = k;
      end else if (t_stall1 < 0) begin
        t_stall1 = k;
      end
    end
  endtask

  initial begin
    vec_t vecs[17];
    int   s0, nf, tf, tr, ts, base;

    for (int i = 0; i < 17; i++) begin
      vecs[i].data     = 8'(8'h11 * i + 8'h3C);
      vecs[i].exp_addr = 4'(i % 16);
    end

    rst = 1'b1;
    prog_mode_i = 1'b0; prog_stb_i = 1'b0; prog_nib_i = 4'h0;
    run_i = 1'b0; halt_i = 1'b0; step_i = 1'b0;
`ifdef TINY_PROC_BREAKPOINT_EN
    pc_i = '0; bp_addr_i = 4'd6; bp_valid_i = 1'b0;
`endif
    tick(3);
    check("rst_state", {29'd0, state_o}, 32'd0);
    check("rst_we", {31'd0, imem_we_o}, 32'd0);
    check("rst_waddr", {28'd0, imem_waddr_o}, 32'd0);
    check("rst_wdata", {24'd0, imem_wdata_o}, 32'd0);
    check("rst_stall", {31'd0, core_stall_o}, 32'd1);
    check("rst_flush", {31'd0, core_flush_o}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Two bytes from nibbles 4,4,F,0
    prog_mode_i = 1'b1;
    tick(4);
    check("enter_load", {29'd0, state_o}, 32'd1);
    load_byte(8'h44, 4'd0);
    load_byte(8'h0F, 4'd1);
    check("waddr_after_two", {28'd0, imem_waddr_o}, 32'd2);
    check("two_writes", wr_count, 32'd2);

    // Seventeen bytes from a fresh load, the last wraps to address 0
    prog_mode_i = 1'b0;
    tick(4);
    prog_mode_i = 1'b1;
    tick(4);
    check("reload_waddr0", {28'd0, imem_waddr_o}, 32'd0);
    base = wr_count;
    for (int i = 0; i < 17; i++) begin
      load_byte(vecs[i].data, vecs[i].exp_addr);
    end
    check("wrap_write_count", wr_count - base, 32'd17);
    check("waddr_after_wrap", {28'd0, imem_waddr_o}, 32'd1);

    // Partial byte abandoned by dropping prog_mode
    base = wr_count;
    strobe(4'h5);
    prog_mode_i = 1'b0;
    tick(4);
    check("abort_state_idle", {29'd0, state_o}, 32'd0);
    check("abort_no_write", wr_count - base, 32'd0);
    check("abort_waddr_kept", {28'd0, imem_waddr_o}, 32'd1);
    prog_mode_i = 1'b1;
    tick(4);
    load_byte(8'hA3, 4'd0);
    check("after_abort_write", wr_count - base, 32'd1);
    prog_mode_i = 1'b0;
    tick(4);
    check("back_idle", {29'd0, state_o}, 32'd0);

    // Run from IDLE: one flush cycle, then stall drops
    run_i = 1'b1;
    watch(8, s0, nf, tf, tr, ts);
    run_i = 1'b0;
    check("flush_count", nf, 32'd1);
    check("flush_time", tf, 32'd3);
    check("run_time", tr, 32'd4);
    check("run_stall0_cycles", s0, 32'd5);
    check("in_run", {29'd0, state_o}, 32'd3);

    halt_i = 1'b1;
    watch(6, s0, nf, tf, tr, ts);
    halt_i = 1'b0;
    check("halt_latency", ts, 32'd3);
    check("halt_stall0_cycles", s0, 32'd2);
    tick(3);
    check("in_halt", {29'd0, state_o}, 32'd4);

    // Three single steps
    for (int i = 0; i < 3; i++) begin
      step_i = 1'b1;
      watch(8, s0, nf, tf, tr, ts);
      step_i = 1'b0;
      check("step_window", s0, 32'd1);
      check("step_no_flush", nf, 32'd0);
      tick(3);
      check("step_back_halt", {29'd0, state_o}, 32'd4);
    end

    // halt beats run; step beats run
    halt_i = 1'b1; run_i = 1'b1;
    watch(8, s0, nf, tf, tr, ts);
    halt_i = 1'b0; run_i = 1'b0;
    check("halt_run_stays", {29'd0, state_o}, 32'd4);
    check("halt_run_stall0", s0, 32'd0);
    tick(3);
    step_i = 1'b1; run_i = 1'b1;
    watch(8, s0, nf, tf, tr, ts);
    step_i = 1'b0; run_i = 1'b0;
    check("step_run_window", s0, 32'd1);
    check("step_run_halt", {29'd0, state_o}, 32'd4);
    tick(3);

    // Resume without flush, prog_mode ignored while running
    run_i = 1'b1;
    watch(8, s0, nf, tf, tr, ts);
    run_i = 1'b0;
    check("resume_no_flush", nf, 32'd0);
    check("resume_time", tr, 32'd3);
    prog_mode_i = 1'b1;
    tick(6);
    check("run_ignores_prog", {29'd0, state_o}, 32'd3);
    halt_i = 1'b1;
    tick(6);
    halt_i = 1'b0;
    check("halt_to_load", {29'd0, state_o}, 32'd1);
    check("halt_load_waddr0", {28'd0, imem_waddr_o}, 32'd0);
    prog_mode_i = 1'b0;
    tick(4);
    check("load_to_idle", {29'd0, state_o}, 32'd0);

`ifdef TINY_PROC_BREAKPOINT_EN
    bp_addr_i = 4'd6; bp_valid_i = 1'b1; pc_i = 4'd0;
    run_i = 1'b1;
    tick(5);
    run_i = 1'b0;
    pc_i = 4'd5;
    #1 check("bp_pc5_runs", {31'd0, core_stall_o}, 32'd0);
    tick(1);
    pc_i = 4'd6;
    #1 check("bp_hit_stall", {31'd0, core_stall_o}, 32'd1);
    check("bp_hit_state_run", {29'd0, state_o}, 32'd3);
    tick(1);
    check("bp_to_halt", {29'd0, state_o}, 32'd4);
    check("bp_halt_stall", {31'd0, core_stall_o}, 32'd1);
    tick(2);
    run_i = 1'b1;
    tick(3);
    check("bp_resume_state", {29'd0, state_o}, 32'd3);
    check("bp_skip_stall", {31'd0, core_stall_o}, 32'd0);
    pc_i = 4'd7;
    tick(1);
    check("bp_no_retrigger", {31'd0, core_stall_o}, 32'd0);
    tick(3);
    run_i = 1'b0;
    check("bp_still_run", {29'd0, state_o}, 32'd3);
    bp_valid_i = 1'b0;
    halt_i = 1'b1;
    tick(5);
    halt_i = 1'b0;
    check("bp_final_halt", {29'd0, state_o}, 32'd4);
`endif

    // Reset in the middle of a byte drops the pending low nibble
    prog_mode_i = 1'b1;
    tick(6);
    strobe(4'h9);
    rst = 1'b1;
    tick(2);
    check("midload_rst_state", {29'd0, state_o}, 32'd0);
    rst = 1'b0;
    tick(4);
    check("post_rst_load", {29'd0, state_o}, 32'd1);
    base = wr_count;
    load_byte(8'h21, 4'd0);
    check("post_rst_write", wr_count - base, 32'd1);
    prog_mode_i = 1'b0;
    tick(4);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
